// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/MEM memory port arbiter.
package mem_arb_pkg;

  // Upper bounds for the latched request fields; module widths must not exceed these.
  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;
  localparam int ARB_BE_W   = ARB_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                  we;
    logic [ARB_BE_W-1:0]   be;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
  } mem_req_t;

  function automatic logic [ARB_BE_W-1:0] full_be(input int n);
    logic [ARB_BE_W-1:0] be;
    for (int i = 0; i < ARB_BE_W; i++) be[i] = (i < n);
    return be;
  endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of data grants made while a fetch is waiting.
module arb_starve_ctr #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic             sat,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sat   = (cnt_q == CNT_W'(STARVE_LIMIT));
    cnt_d = cnt_q;
    if (clr)             cnt_d = '0;
    else if (inc && !sat) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store,
// one latched request at a time with a req/ack handshake to memory.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic                i_kill,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ready,
  output logic                i_stall,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ready,
  output logic                d_stall,
  output logic                m_req,
  output logic                m_we,
  output logic [DATA_W/8-1:0] m_be,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic                m_ack,
  input  logic [DATA_W-1:0]   m_rdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  arb_state_t       state_q, state_d;
  mem_req_t         req_q, req_d;
  logic             killed_q, killed_d;
  logic             idle, grant_d, grant_i;
  logic             starve_inc, starve_clr, starve_sat;
  logic [CNT_W-1:0] starve_cnt;

  arb_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)) u_starve (
    .clk   (clk),
    .reset (reset),
    .inc   (starve_inc),
    .clr   (starve_clr),
    .sat   (starve_sat),
    .cnt   (starve_cnt)
  );

  always_comb begin
    idle     = (state_q == IDLE);
    // Data wins unless it has already taken STARVE_LIMIT grants past a waiting fetch.
    grant_d  = idle && d_req && (!starve_sat || !i_req);
    grant_i  = idle && !grant_d && i_req && !i_kill;
    state_d  = state_q;
    req_d    = req_q;
    killed_d = killed_q;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d                 = BUSY_D;
          req_d                   = '0;
          req_d.we                = d_we;
          req_d.be[BE_W-1:0]      = d_be;
          req_d.addr[ADDR_W-1:0]  = d_addr;
          req_d.wdata[DATA_W-1:0] = d_wdata;
        end else if (grant_i) begin
          state_d                = BUSY_I;
          req_d                  = '0;
          req_d.be               = full_be(BE_W);
          req_d.addr[ADDR_W-1:0] = i_addr;
        end
      end
      BUSY_I: begin
        if (m_ack) begin
          state_d  = IDLE;
          killed_d = 1'b0;
        end else if (i_kill) begin
          killed_d = 1'b1;
        end
      end
      BUSY_D: if (m_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign starve_inc = grant_d && i_req;
  assign starve_clr = grant_i || (idle && !i_req);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      req_q    <= '0;
      killed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      killed_q <= killed_d;
    end
  end

  // A kill arriving with the ack still discards the fetch.
  assign i_ready = !reset && (state_q == BUSY_I) && m_ack && !killed_q && !i_kill;
  assign d_ready = !reset && (state_q == BUSY_D) && m_ack;
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;
  assign i_stall = i_req && !i_ready;
  assign d_stall = d_req && !d_ready;

  assign m_req   = (state_q != IDLE);
  assign m_we    = req_q.we;
  assign m_be    = req_q.be[BE_W-1:0];
  assign m_addr  = req_q.addr[ADDR_W-1:0];
  assign m_wdata = req_q.wdata[DATA_W-1:0];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed + random bench for mem_port_arbiter with a grant/ready scoreboard.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0, reset = 1'b1;
  logic        i_req = 0, i_kill = 0, i_ready, i_stall;
  logic [31:0] i_addr = 0, i_rdata;
  logic        d_req = 0, d_we = 0, d_ready, d_stall;
  logic [3:0]  d_be = 0;
  logic [31:0] d_addr = 0, d_wdata = 0, d_rdata;
  logic        m_req, m_we, m_ack = 0;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata, m_rdata = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill), .i_rdata(i_rdata),
    .i_ready(i_ready), .i_stall(i_stall),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready), .d_stall(d_stall),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  int checks = 0, errors = 0;

  typedef struct {logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata; bit chk_wd;} gexp_t;
  typedef struct {bit is_d; logic [31:0] data; bit chk_data;} rexp_t;
  gexp_t gq[$];
  rexp_t rq[$];
  bit    sb_on = 1'b1;
  int    mem_lat = 0, busy_cyc = 0, nrdy = 0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory model: acks after mem_lat extra busy cycles, data derived from address.
  always @(posedge clk) begin
    #1;
    m_ack = 1'b0;
    if (m_req && !reset) begin
      if (busy_cyc >= mem_lat) begin
        m_ack    = 1'b1;
        m_rdata  = mem_data(m_addr);
        busy_cyc = 0;
      end else busy_cyc++;
    end else busy_cyc = 0;
  end

  // Monitor: scoreboard pops plus protocol invariants.
  logic        pm_req = 0, pm_ack = 0, pwe = 0;
  logic [3:0]  pbe = 0;
  logic [31:0] paddr = 0, pwdata = 0;
  int          rdy_in_grant = 0;

  always @(negedge clk) begin
    gexp_t g;
    rexp_t r;
    chk("dual_ready", i_ready & d_ready, 1'b0);
    chk("i_stall", i_stall, i_req & ~i_ready);
    chk("d_stall", d_stall, d_req & ~d_ready);
    if (m_req && pm_req && !pm_ack)
      chk("m_fields_stable", {m_we, m_be, m_addr, m_wdata}, {pwe, pbe, paddr, pwdata});
    if (m_req && !(pm_req && !pm_ack)) begin
      rdy_in_grant = 0;
      if (sb_on) begin
        checks++;
        if (gq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_grant: got addr %0h expected no grant", m_addr);
        end else begin
          g = gq.pop_front();
          if (m_we !== g.we || m_be !== g.be || m_addr !== g.addr || (g.chk_wd && m_wdata !== g.wdata)) begin
            errors++;
            $display("FAIL grant: got we=%0b be=%0h addr=%0h wd=%0h expected we=%0b be=%0h addr=%0h wd=%0h",
                     m_we, m_be, m_addr, m_wdata, g.we, g.be, g.addr, g.wdata);
          end
        end
      end
    end
    if (i_ready || d_ready) begin
      rdy_in_grant++;
      nrdy++;
      chk("ready_per_grant", (rdy_in_grant <= 1) && m_req, 1'b1);
      if (sb_on) begin
        checks++;
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ready: got i=%0b d=%0b expected none", i_ready, d_ready);
        end else begin
          r = rq.pop_front();
          if (d_ready !== r.is_d || (r.chk_data && (r.is_d ? d_rdata : i_rdata) !== r.data)) begin
            errors++;
            $display("FAIL ready: got d=%0b data=%0h expected d=%0b data=%0h",
                     d_ready, d_ready ? d_rdata : i_rdata, r.is_d, r.data);
          end
        end
      end
    end
    pm_req = m_req; pm_ack = m_ack;
    pwe = m_we; pbe = m_be; paddr = m_addr; pwdata = m_wdata;
  end

  task automatic cyc();
    @(posedge clk); #2;
  endtask

  task automatic wait_rdy(input bit is_d, output int n);
    bit got = 0;
    n = 0;
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      got = is_d ? d_ready : i_ready;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL ready_timeout: got no %s ready expected one within 200 cycles", is_d ? "d" : "i");
    end
  endtask

  task automatic do_fetch(input logic [31:0] a, output int n);
    i_req = 1; i_addr = a;
    wait_rdy(1'b0, n);
    cyc(); i_req = 0;
  endtask

  task automatic do_data(input logic we, input logic [3:0] be, input logic [31:0] a,
                         input logic [31:0] wd, output int n);
    d_req = 1; d_we = we; d_be = be; d_addr = a; d_wdata = wd;
    wait_rdy(1'b1, n);
    cyc(); d_req = 0;
  endtask

  task automatic exp_gi(input logic [31:0] a);
    gq.push_back('{1'b0, 4'hF, a, 32'h0, 1'b0});
  endtask
  task automatic exp_i(input logic [31:0] a);
    exp_gi(a);
    rq.push_back('{1'b0, mem_data(a), 1'b1});
  endtask
  task automatic exp_d(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd);
    gq.push_back('{we, be, a, wd, 1'b1});
    rq.push_back('{1'b1, mem_data(a), !we});
  endtask

  initial begin
    int n, nd, ni;
    logic ir, dr;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_m_req", m_req, 1'b0);
    chk("rst_m_fields", {m_we, m_be, m_addr, m_wdata}, '0);
    chk("rst_ready", {i_ready, d_ready}, 2'b00);
    chk("rst_state", dut.state_q, IDLE);
    chk("rst_starve", dut.starve_cnt, 0);

    // 1: single fetch, ack on second busy cycle
    mem_lat = 1; exp_i(32'h0);
    cyc(); reset = 0;
    do_fetch(32'h0, n);
    chk("t1_latency", n, 3);

    // 2: simultaneous requests, data first
    mem_lat = 0;
    exp_d(1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF); exp_i(32'h4);
    fork
      do_data(1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF, nd);
      do_fetch(32'h4, ni);
    join
    chk("t2_d_latency", nd, 2);
    chk("t2_i_after_dead", ni, 4);

    // 3: starvation limit D,D,D,D,I,D,D
    for (int k = 0; k < 4; k++) exp_d(1'b0, 4'hF, 32'h1000 + 4 * k, 32'h0);
    exp_i(32'h40);
    for (int k = 4; k < 6; k++) exp_d(1'b0, 4'hF, 32'h1000 + 4 * k, 32'h0);
    fork
      for (int k = 0; k < 6; k++) do_data(1'b0, 4'hF, 32'h1000 + 4 * k, 32'h0, nd);
      begin
        do_fetch(32'h40, ni);
        chk("t3_i_wait", ni, 10);
        chk("t3_starve_clr", dut.starve_cnt, 0);
      end
    join

    // 4: kill in BUSY_I, refetch at the redirected address
    mem_lat = 3; exp_gi(32'h200); exp_i(32'h300);
    i_req = 1; i_addr = 32'h200;
    cyc(); i_kill = 1; i_addr = 32'h300;
    cyc(); i_kill = 0;
    wait_rdy(1'b0, n);
    chk("t4_refetch_latency", n, 8);
    cyc(); i_req = 0;

    // 4b: kill in IDLE blocks the grant for that cycle
    mem_lat = 0; exp_i(32'h400);
    i_req = 1; i_addr = 32'h400; i_kill = 1;
    cyc(); i_kill = 0;
    @(negedge clk);
    chk("t4b_kill_blocks", m_req, 1'b0);
    wait_rdy(1'b0, n);
    chk("t4b_latency", n, 1);
    cyc(); i_req = 0;

    // 5: reset during BUSY_D
    mem_lat = 50;
    gq.push_back('{1'b1, 4'hF, 32'h500, 32'h1234_5678, 1'b1});
    d_req = 1; d_we = 1; d_be = 4'hF; d_addr = 32'h500; d_wdata = 32'h1234_5678;
    i_req = 1; i_addr = 32'h600;
    cyc(); reset = 1;
    @(negedge clk);
    chk("t5_busy_before", m_req, 1'b1);
    chk("t5_starve_one", dut.starve_cnt, 1);
    cyc(); reset = 0; d_req = 0; i_req = 0;
    @(negedge clk);
    chk("t5_state", dut.state_q, IDLE);
    chk("t5_m_req", m_req, 1'b0);
    chk("t5_ready", {i_ready, d_ready}, 2'b00);
    chk("t5_starve", dut.starve_cnt, 0);
    mem_lat = 0;
    chk("sb_grants_left", gq.size(), 0);
    chk("sb_readies_left", rq.size(), 0);

    // 6: random traffic, invariants only
    sb_on = 0; nrdy = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk); ir = i_ready; dr = d_ready;
      cyc();
      mem_lat = $urandom_range(0, 3);
      i_kill = 0;
      if (dr) d_req = 0;
      else if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1; d_we = 1'($urandom); d_be = 4'($urandom);
        d_addr = $urandom; d_wdata = $urandom;
      end
      if (ir) i_req = 0;
      else if (!i_req && $urandom_range(0, 2) == 0) begin
        i_req = 1; i_addr = $urandom;
      end else if (i_req && $urandom_range(0, 7) == 0) begin
        i_kill = 1; i_addr = $urandom;
      end
    end
    i_req = 0; d_req = 0; i_kill = 0;
    repeat (10) @(posedge clk);
    checks++;
    if (nrdy == 0) begin
      errors++;
      $display("FAIL random_progress: got %0d ready pulses expected more than 0", nrdy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
